// File: rtl/dmem_pkg.sv
// Shared types and constants for the M-stage data memory and its store buffer.
package dmem_pkg;

  localparam int WORD_W              = 32;
  localparam int DEPTH_WORDS_DEFAULT = 64;
  localparam int SB_DEPTH_DEFAULT    = 4;

  // Entry index field is sized for the largest supported array; narrower indices are zero-extended.
  localparam int SB_IDX_W = 16;

  typedef struct packed {
    logic                valid;
    logic [SB_IDX_W-1:0] idx;
    logic [WORD_W-1:0]   data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer.sv
// Circular store FIFO with head/tail/count and a youngest-first forwarding lookup.
module store_buffer
  import dmem_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEFAULT,
  parameter int IDX_W    = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [IDX_W-1:0]          push_idx,
  input  logic [WORD_W-1:0]         push_data,
  input  logic                      pop,
  input  logic [IDX_W-1:0]          lookup_idx,
  output logic                      hit,
  output logic [WORD_W-1:0]         hit_data,
  output logic [IDX_W-1:0]          head_idx,
  output logic [WORD_W-1:0]         head_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(SB_DEPTH):0] count
);

  localparam int PTR_W = $clog2(SB_DEPTH);

  sb_entry_t        ent_q [SB_DEPTH];
  sb_entry_t        ent_d [SB_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             pop_ok, push_ok;
  logic [SB_DEPTH-1:0] match;
  logic [PTR_W-1:0] lk_pos;

  assign full  = (count_q == (PTR_W+1)'(SB_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign head_idx  = ent_q[head_q].idx[IDX_W-1:0];
  assign head_data = ent_q[head_q].data;

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    // Invalidate before writing: when full, push and pop share the same slot.
    if (pop_ok) begin
      ent_d[head_q].valid = 1'b0;
      head_d              = head_q + 1'b1;
    end
    if (push_ok) begin
      ent_d[tail_q].valid = 1'b1;
      ent_d[tail_q].idx   = SB_IDX_W'(push_idx);
      ent_d[tail_q].data  = push_data;
      tail_d              = tail_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_match
      assign match[gi] = ent_q[gi].valid && (ent_q[gi].idx == SB_IDX_W'(lookup_idx));
    end
  endgenerate

  // Walk oldest to youngest so the last hit seen is the youngest store.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    lk_pos   = head_q;
    for (int i = 0; i < SB_DEPTH; i++) begin
      lk_pos = head_q + PTR_W'(i);
      if (match[lk_pos]) begin
        hit      = 1'b1;
        hit_data = ent_q[lk_pos].data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

endmodule

// File: rtl/dmem_wbuf.sv
// M-stage data memory: word array, buffered core stores, priority debug write port.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter int SB_DEPTH    = SB_DEPTH_DEFAULT,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               ALUOutM,
  input  logic [31:0]               WriteDataM,
  input  logic                      MemWriteM,
  output logic [31:0]               ReadDataM,
  input  logic                      dbg_we,
  input  logic [IDX_W-1:0]          dbg_addr,
  input  logic [31:0]               dbg_wdata,
  output logic [31:0]               dbg_rdata,
  output logic [$clog2(SB_DEPTH):0] sb_count,
  output logic                      sb_empty,
  output logic                      overflow
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0]  core_idx;
  logic              unused_addr_bits;
  logic              sb_hit, sb_full, sb_empty_w;
  logic [WORD_W-1:0] sb_hit_data, sb_head_data;
  logic [IDX_W-1:0]  sb_head_idx;
  logic              drain, drop;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [WORD_W-1:0] mem_wdata;
  logic              overflow_q, overflow_d;

  // Byte offset and high address bits do not select a word; the index wraps.
  assign core_idx         = ALUOutM[IDX_W+1:2];
  assign unused_addr_bits = ^{ALUOutM[31:IDX_W+2], ALUOutM[1:0]};

  store_buffer #(
    .SB_DEPTH (SB_DEPTH),
    .IDX_W    (IDX_W)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .push       (MemWriteM && !reset),
    .push_idx   (core_idx),
    .push_data  (WriteDataM),
    .pop        (drain),
    .lookup_idx (core_idx),
    .hit        (sb_hit),
    .hit_data   (sb_hit_data),
    .head_idx   (sb_head_idx),
    .head_data  (sb_head_data),
    .full       (sb_full),
    .empty      (sb_empty_w),
    .count      (sb_count)
  );

  always_comb begin
    drain      = !reset && !dbg_we && !sb_empty_w;
    drop       = !reset && MemWriteM && sb_full && !drain;
    overflow_d = overflow_q || drop;
    // The debug port owns the write port whenever it is active.
    mem_we     = dbg_we || drain;
    mem_waddr  = dbg_we ? dbg_addr : sb_head_idx;
    mem_wdata  = dbg_we ? dbg_wdata : sb_head_data;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign ReadDataM = sb_hit ? sb_hit_data : mem_q[core_idx];
  assign dbg_rdata = mem_q[dbg_addr];
  assign sb_empty  = sb_empty_w;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_dmem_wbuf.sv
// Randomised and directed checks of dmem_wbuf against a queue-based memory model.
module tb_dmem_wbuf;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUOutM, WriteDataM, ReadDataM;
  logic        MemWriteM;
  logic        dbg_we;
  logic [5:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic [2:0]  sb_count;
  logic        sb_empty, overflow;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } st_t;

  logic [31:0] arr_m [64];
  st_t         q_m [$];
  bit          ovf_m;

  always #5 clk = ~clk;

  dmem_wbuf dut (
    .clk        (clk),
    .reset      (reset),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .MemWriteM  (MemWriteM),
    .ReadDataM  (ReadDataM),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_rdata  (dbg_rdata),
    .sb_count   (sb_count),
    .sb_empty   (sb_empty),
    .overflow   (overflow)
  );

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int idx;
    idx = int'(addr[7:2]);
    for (int i = q_m.size() - 1; i >= 0; i--) begin
      if (q_m[i].idx == idx) return q_m[i].data;
    end
    return arr_m[idx];
  endfunction

  // Advance one clock edge and apply the memory rules to the model.
  task automatic tick();
    bit  drain, accept;
    st_t e;
    @(posedge clk);
    if (reset) begin
      if (dbg_we) arr_m[dbg_addr] = dbg_wdata;
      q_m.delete();
      ovf_m = 1'b0;
    end else begin
      drain  = (q_m.size() > 0) && !dbg_we;
      accept = MemWriteM && ((q_m.size() < 4) || drain);
      if (dbg_we) begin
        arr_m[dbg_addr] = dbg_wdata;
      end else if (drain) begin
        arr_m[q_m[0].idx] = q_m[0].data;
        void'(q_m.pop_front());
      end
      if (accept) begin
        e.idx  = int'(ALUOutM[7:2]);
        e.data = WriteDataM;
        q_m.push_back(e);
      end
      if (MemWriteM && !accept) ovf_m = 1'b1;
    end
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    ALUOutM    = addr;
    WriteDataM = data;
    MemWriteM  = 1'b1;
    $display("[TB] store addr=%h data=%h dbg_we=%0b", addr, data, dbg_we);
    tick();
    MemWriteM = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; MemWriteM = 1'b0; dbg_we = 1'b0; ALUOutM = '0; WriteDataM = '0;
    dbg_addr = '0; dbg_wdata = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_tests++; if (sb_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", sb_count); end
    n_tests++; if (sb_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", sb_empty); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    for (int i = 0; i < 64; i++) begin
      dbg_we = 1'b1; dbg_addr = 6'(i); dbg_wdata = $urandom;
      tick();
    end
    dbg_we = 1'b0;
    $display("[TB] preloaded 64 words via debug port");
    for (int k = 0; k < 8; k++) begin
      dbg_addr = 6'($urandom_range(0, 63));
      #1;
      n_tests++;
      if (dbg_rdata !== arr_m[dbg_addr]) begin
        n_fail++; $display("FAIL preload_read[%0d]: got %h expected %h", dbg_addr, dbg_rdata, arr_m[dbg_addr]);
      end
    end
  endtask

  task automatic test_store_forward();
    store(32'h10, 32'hDEADBEEF);
    ALUOutM = 32'h10;
    #1;
    n_tests++; if (sb_count !== 3'd1) begin n_fail++; $display("FAIL fwd_count: got %0d expected 1", sb_count); end
    n_tests++; if (ReadDataM !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fwd_data: got %h expected deadbeef", ReadDataM); end
    tick();
    dbg_addr = 6'd4;
    #1;
    n_tests++; if (sb_count !== 3'd0) begin n_fail++; $display("FAIL fwd_drained_count: got %0d expected 0", sb_count); end
    n_tests++; if (dbg_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fwd_array: got %h expected deadbeef", dbg_rdata); end
  endtask

  task automatic test_overflow();
    logic [31:0] a;
    dbg_we = 1'b1; dbg_addr = 6'd9; dbg_wdata = $urandom;
    for (int i = 0; i < 4; i++) begin
      a = ($urandom & 32'hFFFF_FF00) | 32'(i * 4) | 32'($urandom_range(0, 3));
      store(a, $urandom);
    end
    #1;
    n_tests++; if (sb_count !== 3'd4) begin n_fail++; $display("FAIL ovf_fill_count: got %0d expected 4", sb_count); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_fill_flag: got %b expected 0", overflow); end
    store(32'h20, $urandom);
    ALUOutM = 32'h20;
    #1;
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    n_tests++; if (sb_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d expected 4", sb_count); end
    n_tests++; if (ReadDataM !== arr_m[8]) begin n_fail++; $display("FAIL ovf_dropped_read: got %h expected %h", ReadDataM, arr_m[8]); end
    dbg_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (sb_count !== 3'(3 - k)) begin n_fail++; $display("FAIL ovf_drain_count: got %0d expected %0d", sb_count, 3 - k); end
    end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 6'(i);
      #1;
      n_tests++;
      if (dbg_rdata !== arr_m[i]) begin n_fail++; $display("FAIL ovf_drained_word[%0d]: got %h expected %h", i, dbg_rdata, arr_m[i]); end
    end
  endtask

  task automatic test_youngest();
    dbg_we = 1'b1; dbg_addr = 6'd30; dbg_wdata = $urandom;
    store(32'h40, 32'h11);
    store(32'h40, 32'h22);
    ALUOutM = 32'h40;
    #1;
    n_tests++; if (ReadDataM !== 32'h22) begin n_fail++; $display("FAIL youngest_fwd: got %h expected 22", ReadDataM); end
    dbg_we = 1'b0;
    tick(); tick();
    dbg_addr = 6'd16;
    #1;
    n_tests++; if (dbg_rdata !== 32'h22) begin n_fail++; $display("FAIL youngest_array: got %h expected 22", dbg_rdata); end
    n_tests++; if (sb_count !== 3'd0) begin n_fail++; $display("FAIL youngest_count: got %0d expected 0", sb_count); end
  endtask

  task automatic test_full_drain();
    logic [31:0] d;
    reset = 1'b1; tick(); reset = 1'b0;
    dbg_we = 1'b1; dbg_addr = 6'd50; dbg_wdata = $urandom;
    for (int i = 0; i < 4; i++) store(32'h100 + 32'(i * 4), $urandom);
    dbg_we = 1'b0;
    d = $urandom;
    store(32'h44, d);
    ALUOutM = 32'h44;
    #1;
    n_tests++; if (sb_count !== 3'd4) begin n_fail++; $display("FAIL fulldrain_count: got %0d expected 4", sb_count); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fulldrain_overflow: got %b expected 0", overflow); end
    n_tests++; if (ReadDataM !== d) begin n_fail++; $display("FAIL fulldrain_fwd: got %h expected %h", ReadDataM, d); end
    for (int k = 0; k < 4; k++) tick();
    dbg_addr = 6'd17;
    #1;
    n_tests++; if (sb_count !== 3'd0) begin n_fail++; $display("FAIL fulldrain_empty: got %0d expected 0", sb_count); end
    n_tests++; if (dbg_rdata !== d) begin n_fail++; $display("FAIL fulldrain_array: got %h expected %h", dbg_rdata, d); end
  endtask

  task automatic test_dbg_vs_buffer();
    dbg_we = 1'b1; dbg_addr = 6'd20; dbg_wdata = $urandom;
    store(32'h0C, 32'h5555);
    ALUOutM = 32'h0C; dbg_addr = 6'd3; dbg_wdata = 32'hAAAA;
    #1;
    n_tests++; if (ReadDataM !== 32'h5555) begin n_fail++; $display("FAIL dbgbuf_fwd0: got %h expected 5555", ReadDataM); end
    tick();
    dbg_we = 1'b0;
    #1;
    n_tests++; if (ReadDataM !== 32'h5555) begin n_fail++; $display("FAIL dbgbuf_fwd1: got %h expected 5555", ReadDataM); end
    n_tests++; if (dbg_rdata !== 32'hAAAA) begin n_fail++; $display("FAIL dbgbuf_raw: got %h expected aaaa", dbg_rdata); end
    tick();
    n_tests++; if (dbg_rdata !== 32'h5555) begin n_fail++; $display("FAIL dbgbuf_array: got %h expected 5555", dbg_rdata); end
    n_tests++; if (ReadDataM !== 32'h5555) begin n_fail++; $display("FAIL dbgbuf_read: got %h expected 5555", ReadDataM); end
    n_tests++; if (sb_count !== 3'd0) begin n_fail++; $display("FAIL dbgbuf_count: got %0d expected 0", sb_count); end
  endtask

  task automatic test_random();
    logic [31:0] tmp, exp_rd;
    logic [2:0]  exp_cnt;
    for (int c = 0; c < 400; c++) begin
      reset     = 1'b0;
      dbg_we    = ($urandom_range(0, 99) < ((c < 200) ? 60 : 20));
      dbg_addr  = 6'($urandom_range(0, 7));
      dbg_wdata = $urandom;
      MemWriteM = 1'($urandom_range(0, 1));
      tmp       = $urandom;
      ALUOutM   = (tmp & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
      WriteDataM = $urandom;
      #1;
      exp_rd  = model_read(ALUOutM);
      exp_cnt = 3'(q_m.size());
      $display("[TB] rnd %0d we=%0b a=%h wd=%h dbg_we=%0b rd=%h cnt=%0d ovf=%0b",
               c, MemWriteM, ALUOutM, WriteDataM, dbg_we, ReadDataM, sb_count, overflow);
      n_tests++; if (ReadDataM !== exp_rd) begin n_fail++; $display("FAIL rnd_read @%0d: got %h expected %h", c, ReadDataM, exp_rd); end
      n_tests++; if (dbg_rdata !== arr_m[dbg_addr]) begin n_fail++; $display("FAIL rnd_dbg @%0d: got %h expected %h", c, dbg_rdata, arr_m[dbg_addr]); end
      n_tests++; if (sb_count !== exp_cnt) begin n_fail++; $display("FAIL rnd_count @%0d: got %0d expected %0d", c, sb_count, exp_cnt); end
      n_tests++; if (sb_empty !== (exp_cnt == 3'd0)) begin n_fail++; $display("FAIL rnd_empty @%0d: got %b expected %b", c, sb_empty, exp_cnt == 3'd0); end
      n_tests++; if (overflow !== ovf_m) begin n_fail++; $display("FAIL rnd_overflow @%0d: got %b expected %b", c, overflow, ovf_m); end
      tick();
    end
    MemWriteM = 1'b0; dbg_we = 1'b0;
  endtask

  task automatic test_reset_discard();
    dbg_we = 1'b1; dbg_addr = 6'd40; dbg_wdata = $urandom;
    for (int i = 0; i < 3; i++) store(32'h80 + 32'(i * 4), ~arr_m[32 + i]);
    dbg_we = 1'b0;
    #1;
    n_tests++; if (sb_count !== 3'd3) begin n_fail++; $display("FAIL rstd_pre_count: got %0d expected 3", sb_count); end
    reset = 1'b1; MemWriteM = 1'b1; ALUOutM = 32'h8C; WriteDataM = ~arr_m[35];
    tick();
    reset = 1'b0; MemWriteM = 1'b0;
    #1;
    n_tests++; if (sb_count !== 3'd0) begin n_fail++; $display("FAIL rstd_count: got %0d expected 0", sb_count); end
    n_tests++; if (sb_empty !== 1'b1) begin n_fail++; $display("FAIL rstd_empty: got %b expected 1", sb_empty); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rstd_overflow: got %b expected 0", overflow); end
    for (int i = 32; i < 36; i++) begin
      ALUOutM = 32'(i * 4);
      #1;
      n_tests++;
      if (ReadDataM !== arr_m[i]) begin n_fail++; $display("FAIL rstd_read[%0d]: got %h expected %h", i, ReadDataM, arr_m[i]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_forward();
    test_overflow();
    test_youngest();
    test_full_drain();
    test_dbg_vs_buffer();
    test_random();
    test_reset_discard();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_wbuf.md
Name: dmem_wbuf

Overview:
Data-memory responder for the pipelined ARM core's M-stage memory interface (ALUOutM, WriteDataM, MemWriteM in; ReadDataM out). Word-addressed storage array with an asynchronous read port. Core stores pass through a small store buffer, which drains to the array one entry per cycle. A debug/preload port has priority on the array write port, and the store buffer absorbs core stores while that port is busy. Reads return same-cycle data, with the youngest buffered store forwarded ahead of the array.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words in the array (power of 2)
SB_DEPTH, 4, store-buffer entries (power of 2, >=2)
IDX_W, $clog2(DEPTH_WORDS), word-index width (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ALUOutM  in  32  byte address from core; word index = ALUOutM[IDX_W+1:2]
WriteDataM  in  32  store data
MemWriteM  in  1  store request this cycle
ReadDataM  out  32  load data, combinational from ALUOutM
dbg_we  in  1  debug/preload array write, priority over drain
dbg_addr  in  IDX_W  debug word index
dbg_wdata  in  32  debug write data
dbg_rdata  out  32  raw array[dbg_addr], combinational, no forwarding
sb_count  out  $clog2(SB_DEPTH)+1  occupied store-buffer entries
sb_empty  out  1  sb_count==0
overflow  out  1  sticky: a core store was dropped

Behaviour:
- Address decoding:
  - ALUOutM[1:0] and bits above IDX_W+1 are ignored.
  - No bounds error; the index wraps modulo DEPTH_WORDS.
- Enqueue:
  - A store is accepted at the rising edge when MemWriteM=1 and the buffer is not full, or when it is full but a drain occurs in the same cycle.
  - Accepted stores are written at the tail as {idx, data, valid}.
  - Core stores never write the array directly.
- Drain:
  - Occurs at each edge when sb_count>0 and dbg_we=0.
  - The head entry is written to the array, then head advances and the entry is invalidated.
  - When dbg_we=1 there is no drain, and dbg_wdata is written to array[dbg_addr].
- Simultaneous enqueue and drain: sb_count is unchanged; head and tail both advance.
- Pointers wrap modulo SB_DEPTH.
- Full case: if sb_count==SB_DEPTH, MemWriteM=1 and no drain this cycle:
  - the store is dropped and overflow is set to 1;
  - overflow stays at 1 until reset;
  - the buffer contents are unchanged.
- Read (ReadDataM):
  - Combinational.
  - If any valid buffer entry matches idx, ReadDataM returns the data of the youngest matching entry (closest to tail).
  - Otherwise it returns array[idx].
  - A store presented in the same cycle is not visible until the next cycle.
- Ordering:
  - Buffered entries drain in FIFO order.
  - If a debug write targets an index that has a pending buffered store, the later drain overwrites it (the buffer wins).
- Latency:
  - A store is visible to reads from the cycle after acceptance, via forwarding.
  - It reaches the array at the earliest on the following edge when dbg_we=0.
- Reset (synchronous):
  - head=tail=0, sb_count=0, all valid=0, sb_empty=1, overflow=0.
  - Pending stores are discarded, and a store presented in the reset cycle is not accepted.
  - The array is NOT cleared, so ReadDataM/dbg_rdata after reset reflect the array contents.
- Reset-value summary: sb_count=0, sb_empty=1, overflow=0; ReadDataM and dbg_rdata are combinational from array/buffer state.

Decomposition:
- Shared package dmem_pkg holds:
  - the word-width constant (32);
  - defaults for DEPTH_WORDS and SB_DEPTH;
  - the store-buffer entry struct {valid, idx, data}.
- Sub-module store_buffer:
  - FIFO with head/tail/count;
  - parallel match lookup with youngest-first priority;
  - outputs: hit, hit_data, head entry, full, empty.
- dmem_wbuf owns:
  - the array;
  - debug-port arbitration;
  - the overflow flag;
  - read muxing.

Test Plan:
1. Reset, then store 0xDEADBEEF at 0x10 with dbg_we=0 → next cycle sb_count=1 and ReadDataM@0x10=0xDEADBEEF (forwarded). The following cycle sb_count=0, and dbg_rdata(idx 4)=0xDEADBEEF.
2. Hold dbg_we=1 writing index 9, and store 4 words to 0x00,0x04,0x08,0x0C → sb_count=4, overflow=0. A 5th store to 0x20 → dropped, overflow=1, ReadDataM@0x20=old array value. Release dbg_we → 4 drain cycles, sb_count=0, overflow still 1.
3. Hold dbg_we=1, store 0x11 then 0x22 to 0x40 → ReadDataM@0x40=0x22. After draining, array[16]=0x22.
4. Buffer full, dbg_we=0, store to 0x44 in the same cycle as a drain → accepted, sb_count stays 4, overflow=0.
5. Debug write 0xAAAA to idx 3 while a buffered store 0x5555 to 0x0C is pending → after drain, array[3]=0x5555 and ReadDataM@0x0C=0x5555 throughout.
6. Assert reset with sb_count=3 and MemWriteM=1 → next cycle sb_count=0, sb_empty=1, overflow=0. ReadDataM at those addresses equals the pre-existing array values (stores lost).
